// File: rtl/resource_ctl_tracker_pkg.sv
// Shared definitions for the resource ctl tracker: o_err bit positions and
// the helper that sizes the stream "mod" field. The stream interface that
// carries dat/ctl/sop/eop/mod/err/val/rdy lives next to this package.
package resource_ctl_tracker_pkg;

    // o_err bit positions
    localparam int ERR_MULTI_BEAT = 0;   // input beat arrived with sop=0 or eop=0
    localparam int ERR_NO_TAG     = 1;   // response arrived with no tag outstanding
    localparam int ERR_BITS       = 2;

    // Width of the byte-modulo field; never narrower than one bit
    function automatic int mod_bits(input int byts);
        return (byts > 1) ? $clog2(byts) : 1;
    endfunction

endpackage

// File: rtl/resource_ctl_tracker_if.sv
// Single-beat capable packet stream (dat/ctl/sop/eop/mod/err with val/rdy).
// source/sink are the names used by the tracker; master/slave are aliases.
interface resource_ctl_tracker_if #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 16
);
    import resource_ctl_tracker_pkg::*;

    localparam int DAT_BITS = DAT_BYTS * 8;
    localparam int MOD_BITS = mod_bits(DAT_BYTS);

    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                sop;
    logic                eop;
    logic [MOD_BITS-1:0] mod;
    logic                err;
    logic                val;
    logic                rdy;

    modport source (output dat, ctl, sop, eop, mod, err, val, input  rdy);
    modport sink   (input  dat, ctl, sop, eop, mod, err, val, output rdy);
    modport master (output dat, ctl, sop, eop, mod, err, val, input  rdy);
    modport slave  (input  dat, ctl, sop, eop, mod, err, val, output rdy);

endinterface

// File: rtl/res_ctl_fifo.sv
// Tag FIFO for the resource ctl tracker. Synchronous, DEPTH entries of
// WIDTH bits, power-of-two depth so the pointers wrap on their own.
// The head is read combinationally so a response can pick up its tag in the
// same cycle it is accepted. A push while full is only taken if a pop frees
// the head in that cycle, so an entry is never overwritten.
module res_ctl_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_reg;
    logic [PTR_BITS-1:0] rd_ptr_reg;
    logic [CNT_BITS-1:0] count_reg;
    logic [CNT_BITS-1:0] count_next;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_BITS'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_dat;
        end
    end

    // Occupancy update: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_BITS'(1);
            2'b01:   count_next = count_reg - CNT_BITS'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count registers with active-low synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/resource_ctl_tracker.sv
// Resource ctl tracker: strips the ctl tag from single-beat requests going
// to a ctl-unaware, in-order resource, stores it, and re-attaches it to the
// matching response. Optional sticky error checks are built only when
// RES_CTL_TRACKER_CHECK_EN is defined; otherwise o_err is tied to zero.
module resource_ctl_tracker
    import resource_ctl_tracker_pkg::*;
#(
    parameter int DAT_BYTS = 8,
    parameter int DAT_BITS = DAT_BYTS * 8,
    parameter int CTL_BITS = 16,
    parameter int MAX_OUT  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    resource_ctl_tracker_if.sink    i_axi,
    output logic [DAT_BITS-1:0]     o_req_dat,
    output logic                    o_req_val,
    input  logic                    i_req_rdy,
    input  logic [DAT_BITS-1:0]     i_rsp_dat,
    input  logic                    i_rsp_val,
    output logic                    o_rsp_rdy,
    resource_ctl_tracker_if.source  o_axi,
    output logic [ERR_BITS-1:0]     o_err
);
    localparam int CNT_BITS = $clog2(MAX_OUT + 1);

    logic [CNT_BITS-1:0] outstanding_reg;
    logic [CNT_BITS-1:0] outstanding_next;
    logic                room;
    logic                push;
    logic                rsp_hs;
    logic                tag_avail;
    logic                pop;
    logic [CTL_BITS-1:0] head_tag;

    logic                out_val_reg;
    logic [DAT_BITS-1:0] out_dat_reg;
    logic [CTL_BITS-1:0] out_ctl_reg;

    logic                fifo_full_unused;
    logic                fifo_empty_unused;
    logic [CNT_BITS-1:0] fifo_count_unused;
    logic                unused_sink;

    // Request path is pure gating: zero latency, blocked once MAX_OUT tags are held
    assign room      = (outstanding_reg < CNT_BITS'(MAX_OUT));
    assign i_axi.rdy = i_req_rdy && room;
    assign o_req_val = i_axi.val && room;
    assign o_req_dat = i_axi.dat;
    assign push      = i_axi.val && i_req_rdy && room;

    // Response path: accept whenever the output register is empty or draining
    assign o_rsp_rdy = !out_val_reg || o_axi.rdy;
    assign rsp_hs    = i_rsp_val && o_rsp_rdy;
    assign tag_avail = (outstanding_reg != '0);
    assign pop       = rsp_hs && tag_avail;

    res_ctl_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (CTL_BITS)
    ) u_tag_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (push),
        .push_dat (i_axi.ctl),
        .pop      (pop),
        .head     (head_tag),
        .full     (fifo_full_unused),
        .empty    (fifo_empty_unused),
        .count    (fifo_count_unused)
    );

    // Outstanding count: +1 on push, -1 on pop, hold on both
    always_comb begin
        outstanding_next = outstanding_reg;
        case ({push, pop})
            2'b10:   outstanding_next = outstanding_reg + CNT_BITS'(1);
            2'b01:   outstanding_next = outstanding_reg - CNT_BITS'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    // Outstanding count register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
        end
    end

    // Output register: load on response, clear once taken, hold under backpressure
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            out_val_reg <= 1'b0;
            out_dat_reg <= '0;
            out_ctl_reg <= '0;
        end else if (rsp_hs) begin
            out_val_reg <= 1'b1;
            out_dat_reg <= i_rsp_dat;
            // An untagged response is still forwarded, carrying ctl=0
            out_ctl_reg <= tag_avail ? head_tag : '0;
        end else if (o_axi.rdy) begin
            out_val_reg <= 1'b0;
        end
    end

    assign o_axi.val = out_val_reg;
    assign o_axi.dat = out_dat_reg;
    assign o_axi.ctl = out_ctl_reg;
    assign o_axi.sop = 1'b1;
    assign o_axi.eop = 1'b1;
    assign o_axi.mod = '0;
    assign o_axi.err = 1'b0;

`ifdef RES_CTL_TRACKER_CHECK_EN
    logic [ERR_BITS-1:0] err_reg;

    // Sticky protocol checks, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            err_reg <= '0;
        end else begin
            if (push && !(i_axi.sop && i_axi.eop)) begin
                err_reg[ERR_MULTI_BEAT] <= 1'b1;
            end
            if (rsp_hs && !tag_avail) begin
                err_reg[ERR_NO_TAG] <= 1'b1;
            end
        end
    end

    assign o_err       = err_reg;
    assign unused_sink = ^{i_axi.mod, i_axi.err};
`else
    assign o_err       = '0;
    assign unused_sink = ^{i_axi.mod, i_axi.err, i_axi.sop, i_axi.eop};
`endif

endmodule

// File: tb/tb_resource_ctl_tracker.sv
// Bench for resource_ctl_tracker. The reference model is a tag queue plus
// the expected contents of the output beat; the resource is modelled by the
// bench itself, answering in request order. Error expectations follow
// whether RES_CTL_TRACKER_CHECK_EN is defined for the build.
module tb_resource_ctl_tracker;
    import resource_ctl_tracker_pkg::*;

    localparam int DAT_BYTS = 8;
    localparam int DAT_BITS = 64;
    localparam int CTL_BITS = 16;
    localparam int MAX_OUT  = 8;
`ifdef RES_CTL_TRACKER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DAT_BITS-1:0] req_dat;
    logic                req_val;
    logic                req_rdy;
    logic [DAT_BITS-1:0] rsp_dat;
    logic                rsp_val;
    logic                rsp_rdy;
    logic [1:0]          err;

    always #5 clk = ~clk;

    resource_ctl_tracker_if #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) in_if ();
    resource_ctl_tracker_if #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) out_if ();

    resource_ctl_tracker #(
        .DAT_BYTS (DAT_BYTS),
        .DAT_BITS (DAT_BITS),
        .CTL_BITS (CTL_BITS),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_axi     (in_if),
        .o_req_dat (req_dat),
        .o_req_val (req_val),
        .i_req_rdy (req_rdy),
        .i_rsp_dat (rsp_dat),
        .i_rsp_val (rsp_val),
        .o_rsp_rdy (rsp_rdy),
        .o_axi     (out_if),
        .o_err     (err)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [CTL_BITS-1:0] tag_q[$];
    logic                exp_val;
    logic [DAT_BITS-1:0] exp_dat;
    logic [CTL_BITS-1:0] exp_ctl;
    logic [1:0]          exp_err;

    task automatic model_reset();
        tag_q.delete();
        exp_val = 1'b0;
        exp_dat = '0;
        exp_ctl = '0;
        exp_err = 2'b00;
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1ns later
    task automatic drive(input logic val, input logic [CTL_BITS-1:0] ctl,
                         input logic [DAT_BITS-1:0] dat, input logic sop,
                         input logic eop, input logic rrdy, input logic rval,
                         input logic [DAT_BITS-1:0] rdat, input logic ordy);
        @(negedge clk);
        in_if.val  = val;
        in_if.ctl  = ctl;
        in_if.dat  = dat;
        in_if.sop  = sop;
        in_if.eop  = eop;
        in_if.mod  = '0;
        in_if.err  = 1'b0;
        req_rdy    = rrdy;
        rsp_val    = rval;
        rsp_dat    = rdat;
        out_if.rdy = ordy;
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, ordy);
    endtask

    // Advance the reference model across the next rising edge
    task automatic advance();
        bit push;
        bit rsp_hs;
        push   = in_if.val && req_rdy && (tag_q.size() < MAX_OUT);
        rsp_hs = rsp_val && (!exp_val || out_if.rdy);
        if (exp_val && out_if.rdy)
            $display("beat out ctl=%h dat=%h", exp_ctl, exp_dat);
        if (rsp_hs) begin
            exp_val = 1'b1;
            exp_dat = rsp_dat;
            if (tag_q.size() > 0) begin
                exp_ctl = tag_q.pop_front();
            end else begin
                exp_ctl = '0;
                if (CHK) exp_err[1] = 1'b1;
            end
        end else if (out_if.rdy) begin
            exp_val = 1'b0;
        end
        if (push) begin
            tag_q.push_back(in_if.ctl);
            if (CHK && !(in_if.sop && in_if.eop)) exp_err[0] = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        idle(1'b1);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            drive(1'b1, 16'(($urandom)), {$urandom, $urandom}, 1'b1, 1'b1, 1'b1,
                  1'b1, {$urandom, $urandom}, 1'b1);
            @(posedge clk);
        end
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL reset_val: got %b want 0", out_if.val); end
        vectors++; if (out_if.dat !== '0) begin miscompares++; $display("FAIL reset_dat: got %h want 0", out_if.dat); end
        vectors++; if (out_if.ctl !== '0) begin miscompares++; $display("FAIL reset_ctl: got %h want 0", out_if.ctl); end
        vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b want 00", err); end
        vectors++; if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b want 1", in_if.rdy); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        $display("txn reset released");
    endtask

    task automatic test_basic();
        drive(1'b1, 16'h0003, 64'hAA, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        vectors++; if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL basic_in_rdy: got %b want 1", in_if.rdy); end
        vectors++; if (req_val !== 1'b1) begin miscompares++; $display("FAIL basic_req_val: got %b want 1", req_val); end
        vectors++; if (req_dat !== 64'hAA) begin miscompares++; $display("FAIL basic_req_dat: got %h want aa", req_dat); end
        advance();
        repeat (2) begin idle(1'b1); advance(); end
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h55AA_00AA, 1'b1);
        vectors++; if (rsp_rdy !== 1'b1) begin miscompares++; $display("FAIL basic_rsp_rdy: got %b want 1", rsp_rdy); end
        advance();
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b1) begin miscompares++; $display("FAIL basic_out_val: got %b want 1", out_if.val); end
        vectors++; if (out_if.dat !== 64'h55AA_00AA) begin miscompares++; $display("FAIL basic_out_dat: got %h want 55aa00aa", out_if.dat); end
        vectors++; if (out_if.ctl !== 16'h0003) begin miscompares++; $display("FAIL basic_out_ctl: got %h want 0003", out_if.ctl); end
        vectors++; if ({out_if.sop, out_if.eop, out_if.mod, out_if.err} !== 6'b110000) begin
            miscompares++; $display("FAIL basic_out_flags: got %b want 110000", {out_if.sop, out_if.eop, out_if.mod, out_if.err}); end
        advance();
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL basic_val_clear: got %b want 0", out_if.val); end
        advance();
    endtask

    task automatic test_ordering();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'(i), 64'(256 + i), 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
            vectors++; if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL order_in_rdy%0d: got %b want 1", i, in_if.rdy); end
            advance();
        end
        for (int i = 0; i <= 4; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, (i < 4), 64'(512 + i), 1'b1);
            if (i > 0) begin
                vectors++; if (out_if.val !== 1'b1 || out_if.ctl !== 16'(i)) begin
                    miscompares++; $display("FAIL order_ctl%0d: got val=%b ctl=%h want val=1 ctl=%h", i, out_if.val, out_if.ctl, 16'(i)); end
                vectors++; if (out_if.dat !== 64'(512 + i - 1)) begin
                    miscompares++; $display("FAIL order_dat%0d: got %h want %h", i, out_if.dat, 64'(512 + i - 1)); end
            end
            advance();
        end
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL order_drained: got %b want 0", out_if.val); end
        advance();
    endtask

    task automatic test_full();
        logic [CTL_BITS-1:0] exp_order [8];
        exp_order = '{16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h20, 16'h21};
        for (int i = 0; i < MAX_OUT; i++) begin
            drive(1'b1, 16'(16 + i), {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
            vectors++; if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL full_fill%0d: got %b want 1", i, in_if.rdy); end
            advance();
        end
        drive(1'b1, 16'h18, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        vectors++; if (in_if.rdy !== 1'b0) begin miscompares++; $display("FAIL full_9th_rdy: got %b want 0", in_if.rdy); end
        vectors++; if (req_val !== 1'b0) begin miscompares++; $display("FAIL full_9th_req_val: got %b want 0", req_val); end
        advance();
        drive(1'b1, 16'h20, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hF0, 1'b1);
        vectors++; if (in_if.rdy !== 1'b0) begin miscompares++; $display("FAIL full_pop_cycle_rdy: got %b want 0", in_if.rdy); end
        advance();
        drive(1'b1, 16'h20, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hF1, 1'b1);
        vectors++; if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL full_rdy_return: got %b want 1", in_if.rdy); end
        vectors++; if (out_if.ctl !== 16'h10) begin miscompares++; $display("FAIL full_first_ctl: got %h want 0010", out_if.ctl); end
        advance();
        drive(1'b1, 16'h21, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        vectors++; if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL full_push_pop_hold: got %b want 1", in_if.rdy); end
        vectors++; if (out_if.ctl !== 16'h11) begin miscompares++; $display("FAIL full_second_ctl: got %h want 0011", out_if.ctl); end
        advance();
        drive(1'b1, 16'h22, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        vectors++; if (in_if.rdy !== 1'b0) begin miscompares++; $display("FAIL full_refilled_rdy: got %b want 0", in_if.rdy); end
        advance();
        for (int i = 0; i <= 8; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, (i < 8), 64'(i), 1'b1);
            if (i > 0) begin
                vectors++; if (out_if.val !== 1'b1 || out_if.ctl !== exp_order[i-1]) begin
                    miscompares++; $display("FAIL full_wrap_ctl%0d: got val=%b ctl=%h want val=1 ctl=%h", i, out_if.val, out_if.ctl, exp_order[i-1]); end
            end
            advance();
        end
        idle(1'b1); advance();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'h31, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0); advance();
        drive(1'b1, 16'h32, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0); advance();
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hD1, 1'b0); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hD2, 1'b0);
            vectors++; if (out_if.val !== 1'b1 || out_if.dat !== 64'hD1 || out_if.ctl !== 16'h31) begin
                miscompares++; $display("FAIL bp_hold%0d: got val=%b dat=%h ctl=%h want 1/d1/0031", i, out_if.val, out_if.dat, out_if.ctl); end
            vectors++; if (rsp_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_rsp_rdy%0d: got %b want 0", i, rsp_rdy); end
            advance();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hD2, 1'b1);
        vectors++; if (rsp_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_release_rdy: got %b want 1", rsp_rdy); end
        advance();
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b1 || out_if.dat !== 64'hD2 || out_if.ctl !== 16'h32) begin
            miscompares++; $display("FAIL bp_second: got val=%b dat=%h ctl=%h want 1/d2/0032", out_if.val, out_if.dat, out_if.ctl); end
        advance();
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b want 0", out_if.val); end
        advance();
    endtask

    task automatic test_errors();
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hE0, 1'b1);
        vectors++; if (rsp_rdy !== 1'b1) begin miscompares++; $display("FAIL err_rsp_rdy: got %b want 1", rsp_rdy); end
        advance();
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b1 || out_if.ctl !== '0 || out_if.dat !== 64'hE0) begin
            miscompares++; $display("FAIL err_untagged: got val=%b ctl=%h dat=%h want 1/0000/e0", out_if.val, out_if.ctl, out_if.dat); end
        vectors++; if (err !== (CHK ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL err_no_tag: got %b want %b", err, (CHK ? 2'b10 : 2'b00)); end
        advance();
        drive(1'b1, 16'h41, 64'h41, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1); advance();
        idle(1'b1);
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL err_multi_beat: got %b want %b", err, exp_err); end
        advance();
        do_reset(2);
        #1;
        vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL err_reset: got %b want 00", err); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(96 + i), '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1); advance();
        end
        do_reset(2);
        drive(1'b1, 16'h77, 64'h7, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1); advance();
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h77, 1'b1); advance();
        idle(1'b1);
        vectors++; if (out_if.val !== 1'b1 || out_if.ctl !== 16'h77) begin
            miscompares++; $display("FAIL midreset_ctl: got val=%b ctl=%h want 1/0077", out_if.val, out_if.ctl); end
        advance();
        idle(1'b1); advance();
    endtask

    task automatic test_random();
        logic                val, rrdy, rval, ordy;
        logic [CTL_BITS-1:0] ctl;
        logic [DAT_BITS-1:0] dat, rdat;
        bit                  room;
        for (int c = 0; c < 400; c++) begin
            val  = ($urandom_range(0, 99) < 60);
            rrdy = ($urandom_range(0, 99) < 80);
            rval = (tag_q.size() > 0) && ($urandom_range(0, 99) < 50);
            ordy = ($urandom_range(0, 99) < 70);
            ctl  = 16'($urandom);
            dat  = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            drive(val, ctl, dat, 1'b1, 1'b1, rrdy, rval, rdat, ordy);
            room = (tag_q.size() < MAX_OUT);
            vectors++; if (in_if.rdy !== (rrdy && room)) begin miscompares++; $display("FAIL rnd_in_rdy c%0d: got %b want %b", c, in_if.rdy, (rrdy && room)); end
            vectors++; if (req_val !== (val && room)) begin miscompares++; $display("FAIL rnd_req_val c%0d: got %b want %b", c, req_val, (val && room)); end
            vectors++; if (req_dat !== dat) begin miscompares++; $display("FAIL rnd_req_dat c%0d: got %h want %h", c, req_dat, dat); end
            vectors++; if (rsp_rdy !== (!exp_val || ordy)) begin miscompares++; $display("FAIL rnd_rsp_rdy c%0d: got %b want %b", c, rsp_rdy, (!exp_val || ordy)); end
            vectors++; if (out_if.val !== exp_val) begin miscompares++; $display("FAIL rnd_out_val c%0d: got %b want %b", c, out_if.val, exp_val); end
            if (exp_val) begin
                vectors++; if (out_if.dat !== exp_dat || out_if.ctl !== exp_ctl) begin
                    miscompares++; $display("FAIL rnd_out_beat c%0d: got dat=%h ctl=%h want dat=%h ctl=%h", c, out_if.dat, out_if.ctl, exp_dat, exp_ctl); end
            end
            advance();
        end
        idle(1'b1);
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL rnd_err: got %b want %b", err, exp_err); end
        advance();
    endtask

    initial begin
        model_reset();
        req_rdy    = 1'b1;
        rsp_val    = 1'b0;
        rsp_dat    = '0;
        out_if.rdy = 1'b1;
        test_reset();
        test_basic();
        test_ordering();
        test_full();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
